// File: rtl/rob_mw.sv
// rob_mw: in-order reorder buffer with multi-wide commit, one store per cycle and mispredict flush recovery
module rob_mw #(
  parameter int DEPTH = 32,
  parameter int COMMIT_W = 2,
  parameter int ARCH_W = 5,
  parameter int PHY_W = 6,
  parameter int ADDR_W = 32,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dis_valid,
  output logic                      dis_ready,
  input  logic                      dis_reg_write,
  input  logic                      dis_inst_sw,
  input  logic [ARCH_W-1:0]         dis_rdaddr,
  input  logic [PHY_W-1:0]          dis_new_phy,
  input  logic [PHY_W-1:0]          dis_prev_phy,
  output logic [TAG_W-1:0]          dis_tag,
  input  logic                      cdb_val,
  input  logic [TAG_W-1:0]          cdb_robtag,
  input  logic [ADDR_W-1:0]         cdb_swaddr,
  input  logic                      cdb_flush,
  input  logic [TAG_W-1:0]          cfc_robtag,
  input  logic                      sb_full,
  output logic [COMMIT_W-1:0]       rob_commit,
  output logic [COMMIT_W-1:0]       rob_commitregwrite,
  output logic [COMMIT_W*ARCH_W-1:0] rob_commitrdaddr,
  output logic [COMMIT_W*PHY_W-1:0] rob_commitprephyaddr,
  output logic [COMMIT_W*PHY_W-1:0] rob_commitcurrphyaddr,
  output logic                      rob_commitmemwrite,
  output logic [ADDR_W-1:0]         rob_swaddr,
  output logic [TAG_W:0]            rob_rdptr,
  output logic [TAG_W:0]            rob_wrptr,
  output logic [TAG_W:0]            rob_count,
  output logic                      rob_full,
  output logic                      rob_two_or_more_vacant
);
  localparam int PW = TAG_W + 1;
  logic [PW-1:0] rd_ptr, wr_ptr, count, n_commit;
  logic [DEPTH-1:0] valid, complete, is_sw, reg_write, killed;
  logic [ARCH_W-1:0] rdaddr_q [DEPTH];
  logic [PHY_W-1:0] new_phy_q [DEPTH];
  logic [PHY_W-1:0] prev_phy_q [DEPTH];
  logic [ADDR_W-1:0] swaddr_q [DEPTH];
  logic [TAG_W-1:0] rd_lo, wr_lo, flush_d, idx;
  logic dis_fire, cdb_hit, ok;
  assign rd_lo = rd_ptr[TAG_W-1:0];
  assign wr_lo = wr_ptr[TAG_W-1:0];
  assign count = rst ? '0 : wr_ptr - rd_ptr;
  assign rob_count = count;
  assign rob_full = count == PW'(DEPTH);
  assign rob_two_or_more_vacant = count <= PW'(DEPTH - 2);
  assign dis_ready = ~rob_full;
  assign dis_tag = wr_lo;
  assign rob_rdptr = rd_ptr;
  assign rob_wrptr = wr_ptr;
  assign flush_d = cfc_robtag - rd_lo;
  assign dis_fire = dis_valid & dis_ready & ~cdb_flush;
  assign cdb_hit = cdb_val & valid[cdb_robtag] & ~(cdb_flush & killed[cdb_robtag]);
  always_comb begin
    killed = '0;
    for (int j = 0; j < DEPTH; j++) killed[j] = TAG_W'(TAG_W'(j) - rd_lo) > flush_d;
  end
  always_comb begin
    rob_commit = '0;
    rob_commitregwrite = '0;
    rob_commitrdaddr = '0;
    rob_commitprephyaddr = '0;
    rob_commitcurrphyaddr = '0;
    rob_commitmemwrite = 1'b0;
    rob_swaddr = '0;
    n_commit = '0;
    idx = '0;
    ok = ~rst;
    for (int i = 0; i < COMMIT_W; i++) begin
      idx = rd_lo + TAG_W'(i);
      ok = ok && (count > PW'(i)) && valid[idx] && complete[idx] &&
           (!is_sw[idx] || (!sb_full && !rob_commitmemwrite));
      rob_commit[i] = ok;
      if (ok) begin
        n_commit = n_commit + PW'(1);
        rob_commitregwrite[i] = reg_write[idx];
        rob_commitrdaddr[i*ARCH_W +: ARCH_W] = rdaddr_q[idx];
        rob_commitprephyaddr[i*PHY_W +: PHY_W] = prev_phy_q[idx];
        rob_commitcurrphyaddr[i*PHY_W +: PHY_W] = new_phy_q[idx];
        if (is_sw[idx]) begin
          rob_commitmemwrite = 1'b1;
          rob_swaddr = swaddr_q[idx];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      valid <= '0;
      complete <= '0;
      is_sw <= '0;
    end else begin
      rd_ptr <= rd_ptr + n_commit;
      if (cdb_flush) begin
        wr_ptr <= rd_ptr + PW'(flush_d) + PW'(1);
        valid <= valid & ~killed;
      end
      for (int i = 0; i < COMMIT_W; i++)
        if (rob_commit[i]) valid[rd_lo + TAG_W'(i)] <= 1'b0;
      if (cdb_hit) complete[cdb_robtag] <= 1'b1;
      if (dis_fire) begin
        wr_ptr <= wr_ptr + PW'(1);
        valid[wr_lo] <= 1'b1;
        complete[wr_lo] <= 1'b0;
        is_sw[wr_lo] <= dis_inst_sw;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (cdb_hit && is_sw[cdb_robtag]) swaddr_q[cdb_robtag] <= cdb_swaddr;
    if (dis_fire) begin
      reg_write[wr_lo] <= dis_reg_write;
      rdaddr_q[wr_lo] <= dis_rdaddr;
      new_phy_q[wr_lo] <= dis_new_phy;
      prev_phy_q[wr_lo] <= dis_prev_phy;
    end
  end
endmodule

// File: tb/tb_rob_mw.sv
// tb_rob_mw: directed table, corner sequences and random traffic against a queue model of rob_mw
module tb_rob_mw;
  logic clk = 1'b0;
  logic rst, dis_valid, dis_ready, dis_reg_write, dis_inst_sw;
  logic [4:0] dis_rdaddr;
  logic [5:0] dis_new_phy, dis_prev_phy;
  logic [2:0] dis_tag, cdb_robtag, cfc_robtag;
  logic cdb_val, cdb_flush, sb_full;
  logic [31:0] cdb_swaddr, rob_swaddr;
  logic [1:0] rob_commit, rob_commitregwrite;
  logic [9:0] rob_commitrdaddr;
  logic [11:0] rob_commitprephyaddr, rob_commitcurrphyaddr;
  logic rob_commitmemwrite, rob_full, rob_two_or_more_vacant;
  logic [3:0] rob_rdptr, rob_wrptr, rob_count;
  int passed = 0, total = 0;
  rob_mw #(.DEPTH(8), .COMMIT_W(2), .ARCH_W(5), .PHY_W(6), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .dis_valid(dis_valid), .dis_ready(dis_ready),
    .dis_reg_write(dis_reg_write), .dis_inst_sw(dis_inst_sw), .dis_rdaddr(dis_rdaddr),
    .dis_new_phy(dis_new_phy), .dis_prev_phy(dis_prev_phy), .dis_tag(dis_tag),
    .cdb_val(cdb_val), .cdb_robtag(cdb_robtag), .cdb_swaddr(cdb_swaddr),
    .cdb_flush(cdb_flush), .cfc_robtag(cfc_robtag), .sb_full(sb_full),
    .rob_commit(rob_commit), .rob_commitregwrite(rob_commitregwrite),
    .rob_commitrdaddr(rob_commitrdaddr), .rob_commitprephyaddr(rob_commitprephyaddr),
    .rob_commitcurrphyaddr(rob_commitcurrphyaddr), .rob_commitmemwrite(rob_commitmemwrite),
    .rob_swaddr(rob_swaddr), .rob_rdptr(rob_rdptr), .rob_wrptr(rob_wrptr),
    .rob_count(rob_count), .rob_full(rob_full), .rob_two_or_more_vacant(rob_two_or_more_vacant)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] tag;
    bit cmp;
    bit sw;
    bit rw;
    logic [4:0] rd;
    logic [5:0] np;
    logic [5:0] pp;
    logic [31:0] sa;
  } ent_t;
  ent_t q[$];
  int rd_p = 0, wr_p = 0, e_n;
  logic [1:0] e_com;
  bit e_mw;
  logic [31:0] e_sa;
  typedef struct {
    bit dv;
    bit cv;
    logic [2:0] ct;
    int cnt;
    bit full;
    bit rdy;
    bit vac;
    logic [1:0] cm;
  } vec_t;
  vec_t tbl[15];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic model_comb();
    e_com = '0;
    e_n = 0;
    e_mw = 0;
    e_sa = '0;
    if (!rst)
      for (int i = 0; i < 2; i++)
        if (e_n == i && i < q.size() && q[i].cmp && (!q[i].sw || (!sb_full && !e_mw))) begin
          e_com[i] = 1'b1;
          e_n++;
          if (q[i].sw) begin
            e_mw = 1;
            e_sa = q[i].sa;
          end
        end
  endtask
  task automatic model_check();
    chk("commit", rob_commit, e_com);
    chk("memwrite", rob_commitmemwrite, e_mw);
    chk("swaddr", rob_swaddr, e_sa);
    for (int i = 0; i < 2; i++)
      if (e_com[i])
        chk($sformatf("lane%0d_fields", i),
            {rob_commitregwrite[i], rob_commitrdaddr[i*5 +: 5], rob_commitprephyaddr[i*6 +: 6], rob_commitcurrphyaddr[i*6 +: 6]},
            {q[i].rw, q[i].rd, q[i].pp, q[i].np});
    if (rst) begin
      chk("rst_count", rob_count, 0);
      chk("rst_full", rob_full, 0);
      chk("rst_ready", dis_ready, 1);
      chk("rst_vac2", rob_two_or_more_vacant, 1);
    end else begin
      chk("count", rob_count, q.size());
      chk("full", rob_full, q.size() == 8);
      chk("ready", dis_ready, q.size() < 8);
      chk("vac2", rob_two_or_more_vacant, q.size() <= 6);
      chk("rdptr", rob_rdptr, rd_p);
      chk("wrptr", rob_wrptr, wr_p);
      chk("dis_tag", dis_tag, wr_p % 8);
    end
  endtask
  task automatic model_update();
    int sz, fp, k;
    ent_t t;
    if (rst) begin
      q.delete();
      rd_p = 0;
      wr_p = 0;
      return;
    end
    sz = q.size();
    fp = -1;
    k = -1;
    for (int j = 0; j < sz; j++) begin
      if (cdb_flush && q[j].tag == cfc_robtag) fp = j;
      if (cdb_val && q[j].tag == cdb_robtag) k = j;
    end
    if (k >= 0 && !(cdb_flush && k > fp)) begin
      t = q[k];
      t.cmp = 1;
      if (t.sw) t.sa = cdb_swaddr;
      q[k] = t;
    end
    if (cdb_flush) begin
      while (q.size() > fp + 1) void'(q.pop_back());
      wr_p = (rd_p + fp + 1) % 16;
    end else if (dis_valid && sz < 8) begin
      t.tag = 3'(wr_p);
      t.cmp = 0;
      t.sw = dis_inst_sw;
      t.rw = dis_reg_write;
      t.rd = dis_rdaddr;
      t.np = dis_new_phy;
      t.pp = dis_prev_phy;
      t.sa = '0;
      q.push_back(t);
      wr_p = (wr_p + 1) % 16;
    end
    repeat (e_n) void'(q.pop_front());
    rd_p = (rd_p + e_n) % 16;
  endtask
  task automatic tick();
    #1;
    model_comb();
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask
  task automatic clr();
    dis_valid = 0;
    cdb_val = 0;
    cdb_flush = 0;
  endtask
  task automatic disp(input bit sw);
    dis_valid = 1;
    dis_inst_sw = sw;
    dis_reg_write = !sw;
    dis_rdaddr = 5'($urandom);
    dis_new_phy = 6'($urandom);
    dis_prev_phy = 6'($urandom);
    tick();
    dis_valid = 0;
  endtask
  task automatic comp(input logic [2:0] t, input logic [31:0] a);
    cdb_val = 1;
    cdb_robtag = t;
    cdb_swaddr = a;
    tick();
    cdb_val = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    clr();
    tick();
    rst = 0;
  endtask
  initial begin
    rst = 1;
    clr();
    sb_full = 0;
    dis_reg_write = 0;
    dis_inst_sw = 0;
    dis_rdaddr = '0;
    dis_new_phy = '0;
    dis_prev_phy = '0;
    cdb_robtag = '0;
    cdb_swaddr = '0;
    cfc_robtag = '0;
    for (int i = 0; i < 9; i++) tbl[i] = '{1, 0, 3'd0, (i < 8) ? i + 1 : 8, i >= 7, i < 7, i < 6, 2'b00};
    tbl[9]  = '{0, 1, 3'd1, 8, 1, 0, 0, 2'b00};
    tbl[10] = '{0, 1, 3'd0, 8, 1, 0, 0, 2'b11};
    tbl[11] = '{0, 0, 3'd0, 6, 0, 1, 1, 2'b00};
    tbl[12] = '{0, 1, 3'd3, 6, 0, 1, 1, 2'b00};
    tbl[13] = '{0, 1, 3'd2, 6, 0, 1, 1, 2'b11};
    tbl[14] = '{0, 0, 3'd0, 4, 0, 1, 1, 2'b00};
    @(negedge clk);
    do_reset();
    chk("reset_count", rob_count, 0);
    chk("reset_wrptr", rob_wrptr, 0);
    for (int r = 0; r < 15; r++) begin
      dis_valid = tbl[r].dv;
      dis_reg_write = 1;
      dis_inst_sw = 0;
      dis_rdaddr = 5'(r);
      dis_new_phy = 6'(r + 8);
      dis_prev_phy = 6'(r + 16);
      cdb_val = tbl[r].cv;
      cdb_robtag = tbl[r].ct;
      tick();
      chk($sformatf("tbl%0d_count", r), rob_count, tbl[r].cnt);
      chk($sformatf("tbl%0d_full", r), rob_full, tbl[r].full);
      chk($sformatf("tbl%0d_ready", r), dis_ready, tbl[r].rdy);
      chk($sformatf("tbl%0d_vac2", r), rob_two_or_more_vacant, tbl[r].vac);
      chk($sformatf("tbl%0d_commit", r), rob_commit, tbl[r].cm);
    end
    clr();
    do_reset();
    disp(1);
    sb_full = 1;
    comp(3'd0, 32'hDEADBEEF);
    #1 chk("sb_hold_commit", rob_commit, 2'b00);
    sb_full = 0;
    #1 chk("sb_release_mw", rob_commitmemwrite, 1);
    chk("sb_release_addr", rob_swaddr, 32'hDEADBEEF);
    tick();
    disp(1);
    disp(1);
    sb_full = 1;
    comp(3'd1, 32'h1111_0001);
    comp(3'd2, 32'h2222_0002);
    sb_full = 0;
    #1 chk("st_pair_first", rob_commit, 2'b01);
    chk("st_pair_first_addr", rob_swaddr, 32'h1111_0001);
    tick();
    #1 chk("st_pair_second", rob_commit, 2'b01);
    chk("st_pair_second_addr", rob_swaddr, 32'h2222_0002);
    tick();
    chk("st_pair_drained", rob_count, 0);
    do_reset();
    repeat (6) disp(0);
    for (int t = 0; t < 6; t++) comp(3'(t), 32'h0);
    repeat (2) tick();
    repeat (7) disp(0);
    chk("wrap_pre_rd", rob_rdptr, 6);
    chk("wrap_pre_wr", rob_wrptr, 13);
    chk("wrap_pre_count", rob_count, 7);
    cdb_flush = 1;
    cfc_robtag = 3'd7;
    tick();
    cdb_flush = 0;
    chk("wrap_wr", rob_wrptr, 8);
    chk("wrap_count", rob_count, 2);
    comp(3'd1, 32'h5);
    chk("wrap_stale_cdb_count", rob_count, 2);
    chk("wrap_stale_cdb_commit", rob_commit, 2'b00);
    comp(3'd6, 32'h0);
    cdb_flush = 1;
    cfc_robtag = 3'd7;
    dis_valid = 1;
    #1 chk("simul_commit", rob_commit, 2'b01);
    tick();
    clr();
    chk("simul_count", rob_count, 1);
    chk("simul_wr", rob_wrptr, 8);
    do_reset();
    repeat (5) disp(0);
    chk("midrst_pre_count", rob_count, 5);
    rst = 1;
    tick();
    rst = 0;
    #1 chk("midrst_count", rob_count, 0);
    chk("midrst_commit", rob_commit, 2'b00);
    chk("midrst_ready", dis_ready, 1);
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 400) == 0;
      sb_full = ($urandom % 10) < 3;
      dis_valid = ($urandom % 10) < 6;
      dis_inst_sw = ($urandom % 10) < 3;
      dis_reg_write = 1'($urandom);
      dis_rdaddr = 5'($urandom);
      dis_new_phy = 6'($urandom);
      dis_prev_phy = 6'($urandom);
      cdb_val = 1'($urandom);
      cdb_swaddr = $urandom;
      if (q.size() > 0 && ($urandom % 5) != 0) cdb_robtag = q[$urandom_range(q.size() - 1, 0)].tag;
      else cdb_robtag = 3'($urandom);
      model_comb();
      cdb_flush = 0;
      if (q.size() > 0 && ($urandom % 20) == 0) begin
        cdb_flush = 1;
        cfc_robtag = q[$urandom_range(q.size() - 1, (e_n > 0) ? e_n - 1 : 0)].tag;
      end
      tick();
    end
    rst = 0;
    clr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rob_mw.md
# rob_mw

Parametrised in-order reorder buffer (ROB) with multi-wide commit. It sits between the dispatch unit and the FRL/CFC/RRAT/store-buffer commit path.
- Allocates one entry per dispatched instruction and marks entries complete from the CDB.
- Retires up to COMMIT_W completed head entries per cycle, at most one of them a store.
- Recovers the write pointer on a branch-mispredict flush.
- Store address is a dedicated field, not overloaded onto register fields.

## Interface
Parameters:
- DEPTH, 32: entries; power of two, 4 to 64. TAG_W = clog2(DEPTH); pointers are TAG_W+1 bits (wrap bit at MSB).
- COMMIT_W, 2: commit lanes, 1 or 2.
- ARCH_W, 5: architectural register index width.
- PHY_W, 6: physical register index width.
- ADDR_W, 32: store address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- dis_valid  in  1  dispatch request.
- dis_ready  out  1  = ~rob_full; dispatch is accepted when dis_valid & dis_ready.
- dis_reg_write  in  1  instruction writes a register.
- dis_inst_sw  in  1  instruction is a store.
- dis_rdaddr  in  ARCH_W  architectural destination.
- dis_new_phy  in  PHY_W  new physical destination; for stores, the rt data physical register.
- dis_prev_phy  in  PHY_W  previous mapping of the destination.
- dis_tag  out  TAG_W  = wr_ptr[TAG_W-1:0], the tag assigned to the accepted instruction.
- cdb_val  in  1  completion broadcast.
- cdb_robtag  in  TAG_W  completing entry.
- cdb_swaddr  in  ADDR_W  store address, latched only if the entry is a store.
- cdb_flush  in  1  mispredict: discard all entries younger than cfc_robtag.
- cfc_robtag  in  TAG_W  tag of the mispredicted branch; always an occupied entry.
- sb_full  in  1  store buffer cannot accept.
- rob_commit  out  COMMIT_W  per-lane retire; lane 0 is the head.
- rob_commitregwrite  out  COMMIT_W  per-lane reg_write.
- rob_commitrdaddr  out  COMMIT_W*ARCH_W  per-lane field; lane i occupies bits [i*ARCH_W +: ARCH_W].
- rob_commitprephyaddr  out  COMMIT_W*PHY_W  per-lane field; to FRL.
- rob_commitcurrphyaddr  out  COMMIT_W*PHY_W  per-lane field; to RRAT.
- rob_commitmemwrite  out  1  a store retires this cycle.
- rob_swaddr  out  ADDR_W  address of the retiring store; 0 when none retires.
- rob_rdptr  out  TAG_W+1  read pointer.
- rob_wrptr  out  TAG_W+1  write pointer.
- rob_count  out  TAG_W+1  occupancy, = wr_ptr - rd_ptr.
- rob_full  out  1  rob_count == DEPTH.
- rob_two_or_more_vacant  out  1  rob_count <= DEPTH-2.

## Operation
- Per-entry state: valid, complete, is_sw, reg_write, rdaddr, new_phy, prev_phy, swaddr.
- Dispatch, when accepted:
  - Write entry[wr_ptr] with valid=1, complete=0, and all dispatch fields.
  - Increment wr_ptr.
  - The full check uses start-of-cycle state; no same-cycle commit bypass.
- Completion: if cdb_val and entry[cdb_robtag].valid, set complete=1. If the entry is a store, also latch swaddr. If the entry is not valid, ignore the broadcast.
- Commit lane i (offset i from rd_ptr) retires only when all of these hold:
  - rob_count > i;
  - the entry is complete;
  - every lane below i retires;
  - if the entry is a store: sb_full=0 and no lower lane retired a store.
- Commit outputs and rob_swaddr are combinational from registered entry state and sb_full.
- For each retiring lane, clear valid. rd_ptr advances by popcount(rob_commit).
- Flush: let d = (cfc_robtag - rd_ptr[TAG_W-1:0]) mod DEPTH.
  - wr_ptr <= rd_ptr + d + 1, full width, so the wrap bit comes out correct. This uses start-of-cycle rd_ptr.
  - Clear valid on every entry at offset > d.
  - Flush overrides dispatch in the same cycle: nothing is written and dis_ready is ignored.
  - Commit in the same cycle proceeds normally; committing entries are never younger than the branch.
  - A completion to a flushed entry in the same cycle is dropped.
- Completion and dispatch to the same index in one cycle cannot occur, because the index is unoccupied. If it does occur, dispatch wins.

## Timing
- Reset, sampled at a rising edge: pointers 0, all valid/complete/is_sw bits 0.
- Output values during reset: rob_count=0, rob_full=0, dis_ready=1, rob_two_or_more_vacant=1, rob_commit=0, rob_commitmemwrite=0, rob_swaddr=0, all other commit fields 0.
- Reset mid-operation discards every entry on that edge.
- Dispatch at edge N makes the entry visible at N+1.
- CDB at edge N lets the entry commit at the earliest in the cycle after N, so completion-to-commit latency is at least 1 cycle.
- Flush at edge N: rob_wrptr and rob_count are correct from N+1; dispatch may resume at N+1.
- Commit output is valid in the same cycle as its inputs; the consumer samples it at the next edge.

## Test plan
- Reset then fill: DEPTH=8, 8 back-to-back dispatches -> rob_full=1 after the 8th; dis_ready=0; a 9th dispatch is not written; rob_two_or_more_vacant=0 from count 7.
- Dual commit: tags 0 and 1 completed -> one cycle with rob_commit=2'b11 and rob_count dropping by 2. Complete tag 3 before tag 2 -> no commit until tag 2 completes.
- Store gating:
  - Head store, sb_full=1 -> rob_commit=0.
  - Drop sb_full -> rob_commitmemwrite=1, rob_swaddr=0xDEADBEEF.
  - Two adjacent completed stores -> one per cycle, never both lanes.
- Flush with wrap: rd_ptr=6, wr_ptr=13 (count 7), cfc_robtag=7 -> wr_ptr=8 next cycle; count=2; CDB to tag 1 afterwards is ignored.
- Simultaneous flush, dispatch and commit: head complete, cdb_flush with cfc_robtag=head+1, dis_valid=1 -> head retires, dispatch is dropped, count=1.
- Reset mid-run: rst asserted with 5 entries -> next cycle count=0, rob_commit=0, dis_ready=1.
